// File: rtl/dm_master.sv
// Data-memory master: LOAD, STORE and byte-wise COPY against a single-port memory.
// Response k cycles after accept (LOAD/STORE 2, COPY 2*len+1, empty/reserved 1); no response backpressure.
module dm_master (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_dst,
    input  logic [7:0] req_len,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       busy,
    output logic       dm_wrt_en,
    output logic [7:0] dm_address,
    output logic [7:0] dm_wrt_data,
    input  logic [7:0] dm_rd_data
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    typedef enum logic [2:0] {IDLE, LOAD, STORE, CP_RD, CP_WR, RESP} state_t;

    state_t     state, state_nxt;
    logic [7:0] addr_q, dst_q, len_q, wdata_q, idx, buffer;
    logic       accept, last_byte;

    assign accept    = req_valid && (state == IDLE);
    assign last_byte = (idx == len_q - 8'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Memory-side outputs decode from the state register only.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        busy        = 1'b1;
        dm_wrt_en   = 1'b0;
        dm_address  = 8'd0;
        dm_wrt_data = 8'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    case (req_op)
                        OP_LOAD:  state_nxt = LOAD;
                        OP_STORE: state_nxt = STORE;
                        OP_COPY:  state_nxt = (req_len != 8'd0) ? CP_RD : RESP;
                        default:  state_nxt = RESP;
                    endcase
                end
            end
            LOAD: begin
                dm_address = addr_q;
                state_nxt  = RESP;
            end
            STORE: begin
                dm_wrt_en   = 1'b1;
                dm_address  = addr_q;
                dm_wrt_data = wdata_q;
                state_nxt   = RESP;
            end
            CP_RD: begin
                dm_address = addr_q + idx;
                state_nxt  = CP_WR;
            end
            CP_WR: begin
                dm_wrt_en   = 1'b1;
                dm_address  = dst_q + idx;
                dm_wrt_data = buffer;
                state_nxt   = last_byte ? RESP : CP_RD;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q    <= 8'd0;
            dst_q     <= 8'd0;
            len_q     <= 8'd0;
            wdata_q   <= 8'd0;
            idx       <= 8'd0;
            buffer    <= 8'd0;
            resp_data <= 8'd0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                dst_q    <= req_dst;
                len_q    <= req_len;
                wdata_q  <= req_wdata;
                idx      <= 8'd0;
                resp_err <= (req_op == 2'b11);
                // Operations that touch no memory complete with zero data.
                if (req_op == 2'b11 || (req_op == OP_COPY && req_len == 8'd0))
                    resp_data <= 8'd0;
            end
            case (state)
                LOAD:  resp_data <= dm_rd_data;
                STORE: resp_data <= wdata_q;
                CP_RD: buffer    <= dm_rd_data;
                CP_WR: begin
                    resp_data <= buffer;
                    if (!last_byte) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
